seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 9 +
 rtl/seg7_scan_hex7seg.sv | 9 +
 rtl/seg7_scan.sv | 92 +++++++++
 tb/tb_seg7_scan.sv | 91 +++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan states, blank code and hex segment table for the 7-seg scanner
package seg7_pkg;
  typedef enum logic {S_BLANK, S_ON} scan_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] hex_to_seg = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg7_scan_hex7seg.sv
// hex7seg: combinational nibble to active-low {g,f,e,d,c,b,a} decoder
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_to_seg[nib_i];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display scanner with frame-boundary shadow commit and blank slots
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DWELL      = 4,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  scan_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, hi_idx;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [VW-1:0]         pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] pend_dots_q, pend_dots_d, disp_dots_q, disp_dots_d;
  logic                  pend_flag_q, pend_flag_d, frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d, seg_dec;
  logic                  dp_q, dp_d, last_tick, commit, lz_blank;
  logic [3:0]            nib;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_BLANK;
      idx_q        <= '0;
      dwell_q      <= '0;
      pend_q       <= '0;
      pend_dots_q  <= '0;
      pend_flag_q  <= 1'b0;
      disp_q       <= '0;
      disp_dots_q  <= '0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dwell_q      <= dwell_d;
      pend_q       <= pend_d;
      pend_dots_q  <= pend_dots_d;
      pend_flag_q  <= pend_flag_d;
      disp_q       <= disp_d;
      disp_dots_q  <= disp_dots_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end
  always_comb begin
    last_tick    = state_q == S_ON && dwell_q == DW'(DWELL - 1);
    commit       = last_tick && idx_q == IW'(NUM_DIGITS - 1);
    state_d      = state_q == S_BLANK ? S_ON : (last_tick ? S_BLANK : S_ON);
    dwell_d      = state_q == S_ON && !last_tick ? DW'(dwell_q + 1'b1) : '0;
    idx_d        = last_tick ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : IW'(idx_q + 1'b1)) : idx_q;
    disp_d       = commit && pend_flag_q ? pend_q : disp_q;
    disp_dots_d  = commit && pend_flag_q ? pend_dots_q : disp_dots_q;
    pend_d       = load ? value : pend_q;
    pend_dots_d  = load ? dots : pend_dots_q;
    pend_flag_d  = load | (pend_flag_q & ~commit);
    frame_done_d = commit;
  end
  // highest nonzero nibble; digits above it are leading zeros
  always_comb begin
    hi_idx = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (disp_q[4*i +: 4] != 4'h0) hi_idx = IW'(i);
  end
  assign nib = disp_q[4*idx_q +: 4];
  hex7seg u_dec (.nib_i(nib), .seg_o(seg_dec));
  always_comb begin
    lz_blank = BLANK_LZ && idx_q > hi_idx;
    an_d     = state_q == S_ON ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d    = state_q == S_ON && !lz_blank ? seg_dec : SEG_BLANK;
    dp_d     = state_q == S_ON ? ~disp_dots_q[idx_q] : 1'b1;
  end
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: table-driven frame checks with a per-tick expectation queue
module tb_seg7_scan;
  typedef logic [7:0][6:0] segs_t;
  typedef struct {
    logic [31:0] val;
    logic [7:0]  dots;
    segs_t       segs;
  } vec_t;
  logic        CLK = 1'b0, RST = 1'b1, load = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dots = '0;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP, frame_done;
  int          checks = 0, passed = 0;
  logic [16:0] sb[$];
  vec_t        vecs[5];
  segs_t       prev_s, zero_s;
  logic [7:0]  prev_d;
  always #5 CLK = ~CLK;
  seg7_scan dut (
    .CLK(CLK), .RST(RST), .load(load), .value(value), .dots(dots),
    .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
  );
  function automatic logic [16:0] outs();
    return {AN, SEG, DP, frame_done};
  endfunction
  task automatic cmp(input string name, input int t, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s tick %0d: got AN=%h SEG=%h DP=%b fd=%b, want AN=%h SEG=%h DP=%b fd=%b",
                  name, t, got[16:9], got[8:2], got[1], got[0], exp[16:9], exp[8:2], exp[1], exp[0]);
  endtask
  task automatic do_load(input logic [31:0] v, input logic [7:0] d);
    value = v;
    dots  = d;
    load  = 1'b1;
  endtask
  task automatic check_frame(input string name, input segs_t s, input logic [7:0] d,
                             input int inj_t, input logic [31:0] inj_v);
    for (int t = 1; t <= 40; t++) begin
      int sl = (t - 1) / 5;
      sb.push_back(((t - 1) % 5) == 0 ? {8'hFF, 7'h7F, 1'b1, t == 40}
                                      : {~(8'd1 << sl), s[sl], ~d[sl], t == 40});
    end
    for (int t = 1; t <= 40; t++) begin
      @(negedge CLK);
      load = 1'b0;
      cmp(name, t, outs(), sb.pop_front());
      if (t == inj_t) do_load(inj_v, 8'h00);
    end
  endtask
  initial begin
    zero_s = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[0] = '{32'h1234_ABCD, 8'h00, {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[1] = '{32'h0000_00F0, 8'h84, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40}};
    vecs[2] = '{32'h0000_0000, 8'h01, zero_s};
    vecs[3] = '{32'h8000_0001, 8'hFF, {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};
    vecs[4] = '{32'h0FED_CBA9, 8'h55, {7'h7F, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10}};
    repeat (3) @(negedge CLK);
    cmp("reset", 0, outs(), {8'hFF, 7'h7F, 1'b1, 1'b0});
    RST    = 1'b0;
    prev_s = zero_s;
    prev_d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].val, vecs[i].dots);
      check_frame($sformatf("vec%0d_prev", i), prev_s, prev_d, 0, 0);
      prev_s = vecs[i].segs;
      prev_d = vecs[i].dots;
    end
    do_load(32'h1111_1111, 8'h00);
    check_frame("double_load_prev", prev_s, prev_d, 10, 32'h2222_2222);
    do_load(32'hAAAA_AAAA, 8'h00);
    check_frame("last_load_wins", {8{7'h24}}, 8'h00, 39, 32'h5555_5555);
    check_frame("commit_cycle_old", {8{7'h08}}, 8'h00, 0, 0);
    check_frame("commit_cycle_new", {8{7'h12}}, 8'h00, 0, 0);
    do_load(32'h9999_9999, 8'hFF);
    for (int t = 1; t <= 29; t++) begin
      @(negedge CLK);
      load = 1'b0;
    end
    cmp("digit5_lit", 29, outs(), {8'hDF, 7'h12, 1'b1, 1'b0});
    RST = 1'b1;
    #1;
    cmp("async_reset", 0, outs(), {8'hFF, 7'h7F, 1'b1, 1'b0});
    #2 RST = 1'b0;
    check_frame("after_reset", zero_s, 8'h00, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
